// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divider helper and the
// default line parameters used by both the RX and TX sides.
package uart_pkg;

    localparam int UART_CLK_FREQ  = 50_000_000;
    localparam int UART_BAUD      = 115_200;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_t;

    // Clocks per oversample tick; truncates, never below one.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clk pulse every DIV clocks.
// A synchronous clear restarts the period so ticks align to a detected edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready output and error pulses.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = UART_CLK_FREQ,
    parameter int BAUD       = UART_BAUD,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_d;
    uart_state_t          state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 start_edge;
    logic                 tick;
    logic                 par_ok;

    // rx is asynchronous: two flops for metastability, a third for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign start_edge = (state == IDLE) && !rx_s && rx_d;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_edge),
        .tick  (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    // Even parity: data bits plus the parity bit must XOR to zero.
    assign par_ok = ~(^shift ^ par_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
        end else if ((state == PARITY) && tick && (tick_cnt == FULL_LAST)) begin
            par_bit <= rx_s;
        end
    end
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            busy        <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state    <= START;
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            // A start bit that is high again at mid-bit was a glitch.
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_idx  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            shift    <= {rx_s, shift[DATA_BITS-1:1]};
                            if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            // Decide at mid stop bit so a following start edge is not missed.
                            state     <= IDLE;
                            busy      <= 1'b0;
                            tick_cnt  <= '0;
                            frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err <= !par_ok;
`endif
                            if (rx_s && par_ok) begin
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shift;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun_err <= 1'b1;
                                end
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model feeding an
// expected-event queue, drained by an independent output monitor.
module tb_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;
    localparam int LAT_MIN  = 154;
    localparam int LAT_MAX  = 156;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun_err;
    logic          parity_err;
    logic          busy;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy)
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    typedef struct {
        logic          is_byte;
        logic [DB-1:0] data;
        logic          ferr;
        logic          perr;
        logic          oerr;
        int            fall_cyc;
    } ev_t;

    ev_t           exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            model_valid = 1'b0;
    logic [DB-1:0] model_data = '0;

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    bit prev_valid = 1'b0;
    bit prev_accept = 1'b0;
    always @(negedge clk) begin
        bit  new_load;
        ev_t e;
        int  lat;
        if (!rst_n) begin
            prev_valid  = 1'b0;
            prev_accept = 1'b0;
        end else begin
            new_load = rx_valid && (!prev_valid || prev_accept);
            if (new_load || frame_err || overrun_err || parity_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got load=%0b ferr=%0b oerr=%0b perr=%0b expected none",
                             new_load, frame_err, overrun_err, parity_err);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_byte", 32'(new_load), 32'(e.is_byte));
                    check("evt_frame_err", 32'(frame_err), 32'(e.ferr));
                    check("evt_overrun_err", 32'(overrun_err), 32'(e.oerr));
`ifdef UART_RX_PARITY_EN
                    check("evt_parity_err", 32'(parity_err), 32'(e.perr));
`endif
                    if (e.is_byte && new_load) begin
                        check("rx_data", 32'(rx_data), 32'(e.data));
                        lat = cyc - e.fall_cyc;
                        checks++;
                        if (lat < LAT_MIN || lat > LAT_MAX) begin
                            errors++;
                            $display("FAIL latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
                        end
                    end
                end
            end
            prev_valid  = rx_valid;
            prev_accept = rx_valid && rx_ready;
        end
    end

    // Driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: frame outcome from the line rules, then drive the bits.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                              input logic par_bit, input int gap);
        ev_t  e;
        logic bad_par;
`ifdef UART_RX_PARITY_EN
        bad_par = (par_bit != ^d);
`else
        bad_par = 1'b0;
`endif
        e.is_byte = 1'b0;
        e.data    = d;
        e.ferr    = 1'b0;
        e.perr    = 1'b0;
        e.oerr    = 1'b0;
        e.fall_cyc = cyc;
        if (!stop_bit || bad_par) begin
            e.ferr = !stop_bit;
            e.perr = bad_par;
        end else if (model_valid) begin
            e.oerr = 1'b1;
        end else begin
            e.is_byte  = 1'b1;
            model_data = d;
            if (!rx_ready) model_valid = 1'b1;
        end
        exp_q.push_back(e);
        rx = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            step(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        step(BIT_CLKS);
`endif
        rx = stop_bit;
        step(BIT_CLKS);
        rx = 1'b1;
        if (gap > 0) step(gap);
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({name, "_rx_data"}, 32'(rx_data), 32'd0);
        check({name, "_frame_err"}, 32'(frame_err), 32'd0);
        check({name, "_overrun_err"}, 32'(overrun_err), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int            busy_cnt;
        int            n;
        logic [DB-1:0] d;
        logic          stop_bit;
        logic          par_bit;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        step(1);
        rst_n = 1'b1;
        step(4);

        // 0xA5 with rx_ready high: one-clk valid pulse
        fork
            send_frame(8'hA5, 1'b1, ^8'hA5, 4);
            begin
                n = 0;
                while (!rx_valid && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                check("a5_valid_seen", 32'(rx_valid), 32'd1);
                @(negedge clk);
                check("a5_valid_width", 32'(rx_valid), 32'd0);
            end
        join
        wait_drain("a5", 50);

        // Short low glitch on an idle line
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        busy_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt < 1 || busy_cnt > 10) begin
            errors++;
            $display("FAIL glitch_busy: got %0d clk expected 1..10", busy_cnt);
        end
        check("glitch_busy_end", 32'(busy), 32'd0);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        step(1);

        // Framing error keeps the previous byte
        send_frame(8'h3C, 1'b0, ^8'h3C, 4);
        wait_drain("ferr", 50);
        check("ferr_valid", 32'(rx_valid), 32'd0);
        check("ferr_hold_data", 32'(rx_data), 32'(model_data));

        // Overrun with consumer stalled
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11, 0);
        send_frame(8'h22, 1'b1, ^8'h22, 4);
        wait_drain("overrun", 50);
        @(negedge clk);
        check("overrun_valid", 32'(rx_valid), 32'd1);
        check("overrun_data", 32'(rx_data), 32'h11);
        step(1);
        rx_ready = 1'b1;
        model_valid = 1'b0;
        step(2);
        check("accept_clears_valid", 32'(rx_valid), 32'd0);

        // Reset in the middle of 0xFF data bits
        rx = 1'b0;
        step(BIT_CLKS);
        rx = 1'b1;
        step(3 * BIT_CLKS);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("midreset");
        end
        step(1);
        rst_n = 1'b1;
        model_data = '0;
        model_valid = 1'b0;
        step(BIT_CLKS * 8);
        check("post_reset_data", 32'(rx_data), 32'd0);
        send_frame(8'h5A, 1'b1, ^8'h5A, 4);
        wait_drain("after_reset", 50);
        check("after_reset_data", 32'(rx_data), 32'h5A);

`ifdef UART_RX_PARITY_EN
        // Parity: wrong then right
        send_frame(8'h07, 1'b1, 1'b0, 4);
        wait_drain("parity_bad", 50);
        check("parity_bad_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h07, 1'b1, 1'b1, 4);
        wait_drain("parity_good", 50);
        check("parity_good_data", 32'(rx_data), 32'h07);
`endif

        // Randomized frames, including back-to-back and bad stop/parity bits
        for (int k = 0; k < 24; k++) begin
            d        = DB'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 4) != 0);
            par_bit  = (^d) ^ ($urandom_range(0, 4) == 0);
            send_frame(d, stop_bit, par_bit,
                       stop_bit ? $urandom_range(0, 20) : $urandom_range(2, 20));
        end
        wait_drain("random", 300);
        check("final_data", 32'(rx_data), 32'(model_data));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
